// File: rtl/cpu_exec_unit_pkg.sv
// Opcode and state encodings shared by the execution stage and its ALU.
package cpu_exec_unit_pkg;

  localparam int OP_BITS = 4;
  typedef logic [OP_BITS-1:0] op_t;

  localparam op_t OP_ADD    = 4'd0;
  localparam op_t OP_SUB    = 4'd1;
  localparam op_t OP_AND    = 4'd2;
  localparam op_t OP_OR     = 4'd3;
  localparam op_t OP_XOR    = 4'd4;
  localparam op_t OP_INC_A  = 4'd5;
  localparam op_t OP_DEC_A  = 4'd6;
  localparam op_t OP_SHL_A  = 4'd7;
  localparam op_t OP_SHR_A  = 4'd8;
  localparam op_t OP_PASS_A = 4'd9;
  localparam op_t OP_PASS_B = 4'd10;
  localparam op_t OP_MOV_AX = 4'd11;
  localparam op_t OP_MOV_XA = 4'd12;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_EXEC = 2'd1,
    EX_WB   = 2'd2,
    EX_DONE = 2'd3
  } ex_state_e;

  // Arithmetic/logic/shift ops and MOV_XA land in A; only MOV_AX lands in X.
  function automatic logic op_writes_a(input op_t op);
    return (op <= OP_SHR_A) || (op == OP_MOV_XA);
  endfunction

  function automatic logic op_writes_x(input op_t op);
    return op == OP_MOV_AX;
  endfunction

endpackage

// File: rtl/cpu_exec_unit_alu.sv
// Combinational ALU: result, carry, whether carry is meaningful, and opcode legality.
module cpu_alu
  import cpu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             carry_valid_o,
  output logic             legal_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    result_o      = '0;
    carry_o       = 1'b0;
    carry_valid_o = 1'b1;
    legal_o       = 1'b1;
    sum           = '0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, x_i};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OP_SUB: begin
        // The extra bit of a WIDTH+1 difference is set exactly when A < X.
        sum      = {1'b0, a_i} - {1'b0, x_i};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OP_AND: result_o = a_i & x_i;
      OP_OR:  result_o = a_i | x_i;
      OP_XOR: result_o = a_i ^ x_i;
      OP_INC_A: begin
        sum      = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OP_DEC_A: begin
        sum      = {1'b0, a_i} - {{WIDTH{1'b0}}, 1'b1};
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OP_SHL_A: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        carry_o  = a_i[WIDTH-1];
      end
      OP_SHR_A: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      OP_PASS_A, OP_MOV_AX: begin
        result_o      = a_i;
        carry_valid_o = 1'b0;
      end
      OP_PASS_B, OP_MOV_XA: begin
        result_o      = x_i;
        carry_valid_o = 1'b0;
      end
      default: begin
        legal_o       = 1'b0;
        carry_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// Execution stage: owns A/X, runs one ALU op per start pulse, writes back and signals done.
//   state   | meaning
//   EX_IDLE | accepts loads and start
//   EX_EXEC | ALU evaluates from A, X, op_q; outcome captured at the edge
//   EX_WB   | destination register, result and flags updated at the edge
//   EX_DONE | done_o (and illegal_o for undefined opcodes) pulse
module cpu_exec_unit
  import cpu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             load_a_i,
  input  logic             load_x_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o
);

  ex_state_e        state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, x_q, res_q, result_q;
  logic             carry_q, zero_q;
  logic             ex_carry_q, ex_zero_q, ex_cvalid_q, ex_legal_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_cvalid, alu_legal;

  cpu_alu #(.WIDTH(WIDTH), .OP_W(OP_W)) u_alu (
    .a_i          (a_q),
    .x_i          (x_q),
    .op_i         (op_q),
    .result_o     (alu_res),
    .carry_o      (alu_carry),
    .carry_valid_o(alu_cvalid),
    .legal_o      (alu_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EX_IDLE: if (start_i) state_d = EX_EXEC;
      EX_EXEC: state_d = EX_WB;
      EX_WB:   state_d = EX_DONE;
      EX_DONE: state_d = EX_IDLE;
      default: state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EX_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      x_q         <= '0;
      res_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ex_carry_q  <= 1'b0;
      ex_zero_q   <= 1'b0;
      ex_cvalid_q <= 1'b0;
      ex_legal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        EX_IDLE: begin
          if (load_a_i) a_q <= a_i;
          if (load_x_i) x_q <= b_i;
          if (start_i)  op_q <= op_i;
        end
        EX_EXEC: begin
          res_q       <= alu_res;
          ex_carry_q  <= alu_carry;
          ex_zero_q   <= (alu_res == '0);
          ex_cvalid_q <= alu_cvalid;
          ex_legal_q  <= alu_legal;
        end
        EX_WB: begin
          // Undefined opcodes commit nothing; only the done/illegal pulse follows.
          if (ex_legal_q) begin
            result_q <= res_q;
            zero_q   <= ex_zero_q;
            if (ex_cvalid_q)       carry_q <= ex_carry_q;
            if (op_writes_a(op_q)) a_q     <= res_q;
            if (op_writes_x(op_q)) x_q     <= res_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_o       = a_q;
  assign x_o       = x_q;
  assign result_o  = result_q;
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;
  assign busy_o    = (state_q != EX_IDLE);
  assign done_o    = (state_q == EX_DONE);
  assign illegal_o = done_o & ~ex_legal_q;

endmodule

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
Execution stage directly downstream of the serial I/O FSM. It owns the architectural registers A and X, which are loaded by the FSM's write_a/write_x strobes from its reg_a_out/reg_b_out buses. The FSM's io_done_o pulse starts one ALU operation, selected by the FSM's reg_op_out. The block writes the result back to A or X, updates the carry and zero flags, and pulses done_o so the display mux and top level can consume the result.

Parameters:
WIDTH, 8, datapath width of A, X and the result.
OP_W, 4, opcode width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
a_i  in  WIDTH  operand bus for A; driven by the FSM's reg_a_out.
b_i  in  WIDTH  operand bus for X; driven by the FSM's reg_b_out.
op_i  in  OP_W  opcode; driven by the FSM's reg_op_out.
load_a_i  in  1  captures a_i into A; driven by the FSM's write_a.
load_x_i  in  1  captures b_i into X; driven by the FSM's write_x.
start_i  in  1  one-cycle pulse that starts execution; driven by the FSM's io_done_o.
a_o  out  WIDTH  current A register.
x_o  out  WIDTH  current X register.
result_o  out  WIDTH  last result, held until the next WB state.
carry_o  out  1  carry/borrow flag.
zero_o  out  1  zero flag.
busy_o  out  1  high while state is not EX_IDLE.
done_o  out  1  one-cycle pulse when the result is committed.
illegal_o  out  1  one-cycle pulse, coincident with done_o, when the opcode is undefined.

Behaviour:
- Reset (rst_i=1 at a rising edge): A, X, result_o, carry_o, zero_o = 0; state = EX_IDLE; busy_o, done_o, illegal_o = 0. Reset mid-operation aborts the operation. No writeback and no done_o follow.
- Loads are honoured only in EX_IDLE.
  - load_a_i: A <= a_i. load_x_i: X <= b_i. Both may be asserted in the same cycle.
  - Loads in any other state are ignored.
- FSM states: EX_IDLE -> EX_EXEC -> EX_WB -> EX_DONE -> EX_IDLE.
  - EX_IDLE: if start_i, latch op_q <= op_i and go to EX_EXEC. A load in the same cycle as start_i is captured, and execution uses the new A/X value.
  - EX_EXEC: the ALU evaluates combinationally from A, X and op_q. At the clock edge, res_q, carry_d and zero_d are latched. Go to EX_WB.
  - EX_WB: update the destination register, result_o and the flags. Go to EX_DONE.
  - EX_DONE: done_o=1 (plus illegal_o if applicable). Go to EX_IDLE.
- Latency: start_i sampled at edge t; destination register updated at edge t+2; done_o high during cycle t+3. Back-to-back start is accepted in the cycle after EX_DONE.
- start_i is ignored while busy_o=1. No queueing.
- Opcodes (OP_W=4) and their effects:
  - ADD=0: A <= A+X; carry = carry-out.
  - SUB=1: A <= A-X; carry = borrow (A<X).
  - AND=2, OR=3, XOR=4: A <= A op X; carry = 0.
  - INC_A=5: A <= A+1; carry = 1 only if A was FF.
  - DEC_A=6: A <= A-1; carry = 1 only if A was 00.
  - SHL_A=7: A <= A<<1; carry = old A[7].
  - SHR_A=8: A <= A>>1, logical; carry = old A[0].
  - PASS_A=9: A unchanged; result = A.
  - PASS_B=10: result = X; X unchanged.
  - MOV_AX=11: X <= A.
  - MOV_XA=12: A <= X.
  - PASS and MOV opcodes leave carry unchanged.
- zero = (result == 0) for every defined opcode.
- Undefined opcodes 13-15: no register or flag change and result_o unchanged; done_o and illegal_o both pulse.
- Arithmetic is modulo 2^WIDTH. The carry-out is taken from a WIDTH+1 sum.

Decomposition:
- operations.vh holds the OP_ codes above.
- states.vh gains EX_IDLE, EX_EXEC, EX_WB and EX_DONE (2 bits).
- One natural combinational sub-module, cpu_alu, takes (a, x, op) and returns (result, carry, carry_valid, legal). cpu_exec_unit holds the FSM, registers and writeback.

Test Plan:
- Reset check: after reset, all outputs are 0. Load A=0x05 and X=0x03, then pulse start with op=ADD. Expect A=0x08, carry=0, zero=0, done_o exactly 3 cycles after start, busy_o high for 3 cycles.
- Carry and zero wrap: A=0xFF, X=0x01, ADD gives A=0x00, carry=1, zero=1. Then INC_A on A=0xFF gives 0x00 with carry=1. Then DEC_A on A=0x00 gives 0xFF with carry=1.
- Subtract with borrow: A=0x03, X=0x05, SUB gives A=0xFE, carry=1. Shifts: SHR_A on A=0x81 gives 0x40 with carry=1. SHL_A on A=0x81 gives 0x02 with carry=1.
- Moves: A=0x3C, X=0xA5. MOV_AX gives X=0x3C with A unchanged. MOV_XA then gives A=0x3C. A PASS_B that yields a nonzero result sets zero=0 and leaves carry unchanged.
- Busy protection: a second start, load_a=1 and a_i=0x77 all applied during EX_EXEC are ignored. A keeps the first result and only one done_o pulse occurs.
- Illegal opcode and reset: op=14 gives done_o and illegal_o pulses with A, X and flags unchanged. Asserting rst_i during EX_WB clears everything and no done_o follows.
